// File: rtl/rn_diag_mac.sv
// rn_diag_mac: diagnosis compute stage between the rn_diag_param FIFO
// (16-bit, standard non-FWFT) and the rn_diag_result FIFO (32-bit).
// Each packet is a header, a bias and N weight/input pairs (signed Q8.8).
// The stage computes bias + sum(w*x) in Q16.16, applies an optional ReLU,
// saturates the result to 32 bits and writes one result word per packet.
//
// Ports:
//   iClk            bus_clk
//   iReset          synchronous active-high reset (param pipe open)
//   i16ParamData    param FIFO dout, valid the cycle after oParamRead
//   iParamEmpty     param FIFO empty
//   oParamRead      param FIFO rd_en
//   o32ResultData   result FIFO din, qualified by oResultWrite
//   oResultWrite    result FIFO wr_en
//   iResultFull     result FIFO full
//   oBusy           high while a packet is in progress
//   oMagicErr       sticky bad-header flag, cleared only by reset
//   o16ResultCount  results written since reset (wraps)
module rn_diag_mac #(
  parameter int unsigned ACC_W = 40,
  parameter logic [3:0]  MAGIC = 4'hA
) (
  input  logic        iClk,
  input  logic        iReset,
  input  logic [15:0] i16ParamData,
  input  logic        iParamEmpty,
  output logic        oParamRead,
  output logic [31:0] o32ResultData,
  output logic        oResultWrite,
  input  logic        iResultFull,
  output logic        oBusy,
  output logic        oMagicErr,
  output logic [15:0] o16ResultCount
);

  typedef enum logic [3:0] {
    IDLE,
    HDR_DATA,
    BIAS_FETCH,
    BIAS_DATA,
    W_FETCH,
    W_DATA,
    X_FETCH,
    X_DATA,
    SAT,
    OUT
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t           r_state;
  state_t           w_next;

  logic             r_relu;
  logic [10:0]      r_pairs;
  logic [15:0]      r_w;
  logic [ACC_W-1:0] r_acc;
  logic [31:0]      r_res;
  logic             r_magic_err;
  logic [15:0]      r_count;

  logic             w_fetch;
  logic             w_read;
  logic             w_write;
  logic             w_magic_ok;
  logic [31:0]      w_prod;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W-1:0] w_acc_next;
  logic [ACC_W-1:0] w_bias_acc;
  logic [ACC_W-32:0] w_hi;
  logic             w_fits;
  logic [31:0]      w_sat;
  logic [31:0]      w_res;

  // Fetch states issue at most one read; the following x_DATA state consumes it.
  assign w_fetch    = (r_state == IDLE) || (r_state == BIAS_FETCH) ||
                      (r_state == W_FETCH) || (r_state == X_FETCH);
  assign w_read     = w_fetch && !iParamEmpty && !iReset;
  assign w_write    = (r_state == OUT) && !iResultFull && !iReset;
  assign w_magic_ok = (i16ParamData[15:12] == MAGIC);

  // Low 32 bits of the sign-extended product equal the signed 16x16 product.
  assign w_prod = {{16{r_w[15]}}, r_w} * {{16{i16ParamData[15]}}, i16ParamData};

  // Add with one extra bit; on overflow clamp to the accumulator range so the
  // accumulator never wraps and the later 32-bit saturation stays correct.
  assign w_sum      = {r_acc[ACC_W-1], r_acc} + {{(ACC_W-31){w_prod[31]}}, w_prod};
  assign w_acc_next = (w_sum[ACC_W] != w_sum[ACC_W-1]) ?
                      (w_sum[ACC_W] ? ACC_MIN : ACC_MAX) : w_sum[ACC_W-1:0];

  // Q8.8 bias to Q16.16: sign-extend and shift left by 8.
  assign w_bias_acc = {{(ACC_W-24){i16ParamData[15]}}, i16ParamData, 8'h00};

  // Value fits in 32 signed bits when bits [ACC_W-1:31] are all equal.
  assign w_hi   = r_acc[ACC_W-1:31];
  assign w_fits = (&w_hi) || !(|w_hi);
  assign w_sat  = w_fits ? r_acc[31:0] :
                  (r_acc[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF);
  assign w_res  = (r_relu && w_sat[31]) ? '0 : w_sat;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:       if (w_read) w_next = HDR_DATA;
      HDR_DATA:   w_next = w_magic_ok ? BIAS_FETCH : IDLE;
      BIAS_FETCH: if (w_read) w_next = BIAS_DATA;
      BIAS_DATA:  w_next = (r_pairs == '0) ? SAT : W_FETCH;
      W_FETCH:    if (w_read) w_next = W_DATA;
      W_DATA:     w_next = X_FETCH;
      X_FETCH:    if (w_read) w_next = X_DATA;
      X_DATA:     w_next = (r_pairs == 11'd1) ? SAT : W_FETCH;
      SAT:        w_next = OUT;
      OUT:        if (!iResultFull) w_next = IDLE;
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      r_state     <= IDLE;
      r_relu      <= 1'b0;
      r_pairs     <= '0;
      r_w         <= '0;
      r_acc       <= '0;
      r_res       <= '0;
      r_magic_err <= 1'b0;
      r_count     <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        HDR_DATA: begin
          if (w_magic_ok) begin
            r_relu  <= i16ParamData[11];
            r_pairs <= i16ParamData[10:0];
          end else begin
            r_magic_err <= 1'b1;
          end
        end
        BIAS_DATA: r_acc <= w_bias_acc;
        W_DATA:    r_w   <= i16ParamData;
        X_DATA: begin
          r_acc   <= w_acc_next;
          r_pairs <= r_pairs - 11'd1;
        end
        SAT:       r_res <= w_res;
        OUT:       if (w_write) r_count <= r_count + 16'd1;
        default: ;
      endcase
    end
  end

  assign oParamRead     = w_read;
  assign oResultWrite   = w_write;
  assign o32ResultData  = r_res;
  assign oBusy          = (r_state != IDLE);
  assign oMagicErr      = r_magic_err;
  assign o16ResultCount = r_count;

endmodule

// File: tb/tb_rn_diag_mac.sv
// Testbench for rn_diag_mac: FIFO model for the param side, arithmetic
// reference for each packet result, scoreboard on every result write.
module tb_rn_diag_mac;

  localparam int MODEL_ACC_W = 40;

  logic        iClk = 1'b0;
  logic        iReset;
  logic [15:0] i16ParamData;
  logic        iParamEmpty;
  logic        oParamRead;
  logic [31:0] o32ResultData;
  logic        oResultWrite;
  logic        iResultFull;
  logic        oBusy;
  logic        oMagicErr;
  logic [15:0] o16ResultCount;

  always #5 iClk = ~iClk;

  rn_diag_mac #(.ACC_W(40), .MAGIC(4'hA)) dut (
    .iClk          (iClk),
    .iReset        (iReset),
    .i16ParamData  (i16ParamData),
    .iParamEmpty   (iParamEmpty),
    .oParamRead    (oParamRead),
    .o32ResultData (o32ResultData),
    .oResultWrite  (oResultWrite),
    .iResultFull   (iResultFull),
    .oBusy         (oBusy),
    .oMagicErr     (oMagicErr),
    .o16ResultCount(o16ResultCount)
  );

  logic [15:0] q[$];
  logic [15:0] pkt[$];
  logic [31:0] exp_q[$];
  int          n_assert = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  bit          starve = 1'b0;
  bit          rnd_full = 1'b0;
  bit          model_err = 1'b0;
  logic [15:0] exp_cnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  // Reference: exact integer arithmetic, accumulator clamped to its signed range.
  function automatic logic [31:0] model_result();
    longint acc;
    longint amax;
    longint amin;
    longint lim;
    int     n;
    logic [31:0] r;
    amax = (longint'(1) <<< (MODEL_ACC_W - 1)) - 1;
    amin = -(longint'(1) <<< (MODEL_ACC_W - 1));
    lim  = longint'(1) <<< 31;
    n    = int'(pkt[0][10:0]);
    acc  = longint'($signed(pkt[1])) * 256;
    for (int i = 0; i < n; i++) begin
      acc = acc + longint'($signed(pkt[2 + 2*i])) * longint'($signed(pkt[3 + 2*i]));
      if (acc > amax) acc = amax;
      if (acc < amin) acc = amin;
    end
    if (acc > lim - 1)   r = 32'h7FFF_FFFF;
    else if (acc < -lim) r = 32'h8000_0000;
    else                 r = acc[31:0];
    if (pkt[0][11] && r[31]) r = '0;
    return r;
  endfunction

  task automatic push_packet(output logic [31:0] e);
    if (pkt[0][15:12] != 4'hA) begin
      model_err = 1'b1;
      e = '0;
    end else begin
      e = model_result();
      exp_q.push_back(e);
    end
    foreach (pkt[i]) q.push_back(pkt[i]);
  endtask

  task automatic set_basic();
    pkt.delete();
    pkt.push_back(16'hA002); pkt.push_back(16'h0100);
    pkt.push_back(16'h0200); pkt.push_back(16'h0180);
    pkt.push_back(16'hFF00); pkt.push_back(16'h0100);
  endtask

  task automatic set2(input logic [15:0] a, input logic [15:0] b);
    pkt.delete();
    pkt.push_back(a);
    pkt.push_back(b);
  endtask

  // One clock: checks at the falling edge, FIFO model updated just after the rising edge.
  task automatic step();
    bit rd;
    @(negedge iClk);
    if (!iReset) begin
      n_assert++;
      if (oParamRead && iParamEmpty) begin
        n_fail++;
        $display("FAIL rd_while_empty: got oParamRead=1 with iParamEmpty=1, required 0 (cycle %0d)", cyc);
      end
      if (oResultWrite) begin
        if (exp_q.size() == 0) begin
          n_assert++;
          n_fail++;
          $display("FAIL unexpected_write: got write of 0x%08h, required no write", o32ResultData);
        end else begin
          chk("result_data", o32ResultData, exp_q.pop_front());
          chk("result_count", {16'h0, o16ResultCount}, {16'h0, exp_cnt});
          exp_cnt++;
        end
      end
    end
    rd = oParamRead;
    @(posedge iClk);
    #1;
    cyc++;
    if (rd) begin
      if (q.size() > 0) i16ParamData = q.pop_front();
      else begin
        n_assert++;
        n_fail++;
        $display("FAIL fifo_underflow: got read of empty FIFO, required no read");
      end
    end
    if (rnd_full) iResultFull = ($urandom_range(0, 3) == 0);
    iParamEmpty = (q.size() == 0) || (starve && (cyc % 5 != 0));
  endtask

  task automatic wait_idle(input string name, input int limit);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    while (!done && n < limit) begin
      step();
      n++;
      done = (q.size() == 0) && (exp_q.size() == 0) && !oBusy;
    end
    n_assert++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_timeout: got no idle after %0d cycles, required idle", name, limit);
    end
  endtask

  task automatic drain(input string name, input int limit);
    int n;
    n = 0;
    while (q.size() != 0 && n < limit) begin
      step();
      n++;
    end
    n_assert++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d words left, required 0", name, q.size());
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_read"},  {31'b0, oParamRead},   32'h0);
    chk({tag, "_write"}, {31'b0, oResultWrite}, 32'h0);
    chk({tag, "_data"},  o32ResultData,         32'h0);
    chk({tag, "_busy"},  {31'b0, oBusy},        32'h0);
    chk({tag, "_merr"},  {31'b0, oMagicErr},    32'h0);
    chk({tag, "_count"}, {16'h0, o16ResultCount}, 32'h0);
  endtask

  initial begin
    logic [31:0] e;
    logic [15:0] hdr;
    int          n;

    iReset = 1'b1;
    i16ParamData = '0;
    iParamEmpty = 1'b1;
    iResultFull = 1'b0;
    repeat (3) step();
    chk_all_zero("reset");
    iReset = 1'b0;
    step();

    // Basic packet
    set_basic();
    push_packet(e);
    chk("model_basic", e, 32'h0003_0000);
    wait_idle("basic", 200);
    chk("count_basic", {16'h0, o16ResultCount}, 32'd1);
    chk("merr_basic", {31'b0, oMagicErr}, 32'h0);

    // ReLU and negative bias
    set2(16'hA800, 16'hFE00);
    push_packet(e);
    chk("model_relu", e, 32'h0000_0000);
    wait_idle("relu", 100);
    set2(16'hA000, 16'hFE00);
    push_packet(e);
    chk("model_negbias", e, 32'hFFFE_0000);
    wait_idle("negbias", 100);

    // Saturation with the maximum pair count
    set2(16'hA7FF, 16'h0000);
    for (int i = 0; i < 2047; i++) begin
      pkt.push_back(16'h7FFF);
      pkt.push_back(16'h7FFF);
    end
    push_packet(e);
    chk("model_sat", e, 32'h7FFF_FFFF);
    wait_idle("sat", 10000);

    // N = 0, most negative bias
    set2(16'hA000, 16'h8000);
    push_packet(e);
    chk("model_n0", e, 32'hFF80_0000);
    wait_idle("n0", 100);
    chk("count_n0", {16'h0, o16ResultCount}, 32'd5);

    // Bad magic then a good packet
    pkt.delete();
    pkt.push_back(16'h1234);
    push_packet(e);
    set_basic();
    push_packet(e);
    wait_idle("badmagic", 200);
    chk("merr_set", {31'b0, oMagicErr}, {31'b0, model_err});
    chk("count_badmagic", {16'h0, o16ResultCount}, 32'd6);

    // Param FIFO starvation
    starve = 1'b1;
    set_basic();
    push_packet(e);
    wait_idle("starve", 500);
    starve = 1'b0;
    chk("count_starve", {16'h0, o16ResultCount}, 32'd7);

    // Result FIFO backpressure held at OUT
    iResultFull = 1'b1;
    set_basic();
    push_packet(e);
    drain("full", 100);
    repeat (6) step();
    for (int i = 0; i < 20; i++) begin
      chk("stall_write", {31'b0, oResultWrite}, 32'h0);
      chk("stall_data", o32ResultData, e);
      chk("stall_busy", {31'b0, oBusy}, 32'h1);
      step();
    end
    iResultFull = 1'b0;
    step();
    chk("write_after_full", exp_q.size(), 32'd0);
    step();
    chk("count_full", {16'h0, o16ResultCount}, 32'd8);
    chk("merr_sticky", {31'b0, oMagicErr}, 32'h1);

    // Reset mid-packet with a weight read in flight
    q.push_back(16'hA002);
    q.push_back(16'h0100);
    q.push_back(16'h0200);
    drain("midrst", 100);
    repeat (2) step();
    iReset = 1'b1;
    q.delete();
    exp_q.delete();
    exp_cnt = '0;
    model_err = 1'b0;
    step();
    chk_all_zero("midrst");
    iReset = 1'b0;
    step();
    set_basic();
    push_packet(e);
    wait_idle("after_rst", 200);
    chk("count_after_rst", {16'h0, o16ResultCount}, 32'd1);
    chk("merr_after_rst", {31'b0, oMagicErr}, 32'h0);

    // Randomized packets with random backpressure and starvation
    rnd_full = 1'b1;
    for (int p = 0; p < 40; p++) begin
      starve = (p % 2 == 1);
      pkt.delete();
      if (p == 3 || $urandom_range(0, 7) == 0) begin
        hdr = 16'($urandom);
        if (hdr[15:12] == 4'hA) hdr[15:12] = 4'h5;
        pkt.push_back(hdr);
      end else begin
        n = $urandom_range(0, 6);
        hdr = {4'hA, 1'($urandom_range(0, 1)), 11'(n)};
        pkt.push_back(hdr);
        pkt.push_back(16'($urandom));
        for (int i = 0; i < 2 * n; i++) pkt.push_back(16'($urandom));
      end
      push_packet(e);
    end
    wait_idle("random", 20000);
    rnd_full = 1'b0;
    starve = 1'b0;
    iResultFull = 1'b0;
    chk("merr_random", {31'b0, oMagicErr}, {31'b0, model_err});
    step();
    chk("count_random", {16'h0, o16ResultCount}, {16'h0, exp_cnt});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rn_diag_mac.md
Name: rn_diag_mac

Overview:
- Diagnosis compute stage between the rn_diag_param host-to-FPGA FIFO (16-bit) and the rn_diag_result FPGA-to-host FIFO (32-bit), clocked on bus_clk.
- Consumes packets of the form header, bias, then N weight/input pairs, all signed Q8.8.
- Computes bias + Σ(w·x) in Q16.16 with an optional ReLU, saturates to 32 bits, and pushes one result word per packet.

Parameters:
- ACC_W, 40, accumulator width in bits (≥ 32 + 11 guard bits not required; saturation covers overflow).
- MAGIC, 4'hA, required value of header[15:12].

Ports:
- iClk  in  1  bus_clk; single clock domain.
- iReset  in  1  synchronous, active-high reset; driven by user_w_rn_diag_param_open.
- i16ParamData  in  16  param FIFO dout; valid the cycle after oParamRead (standard, non-FWFT FIFO).
- iParamEmpty  in  1  param FIFO empty.
- oParamRead  out  1  param FIFO rd_en.
- o32ResultData  out  32  result FIFO din.
- oResultWrite  out  1  result FIFO wr_en.
- iResultFull  in  1  result FIFO full.
- oBusy  out  1  high while a packet is in progress (any state except IDLE).
- oMagicErr  out  1  sticky; set on a bad header, cleared only by reset.
- o16ResultCount  out  16  results written since reset; wraps at 0xFFFF→0.

Behaviour:
- Reset values: every output is 0. State is IDLE; accumulator, pair counter and relu flag are cleared.
- Reset mid-packet aborts the packet. Data from a read already in flight is ignored; no result is written.
- Read rule:
  - At most one read is outstanding.
  - oParamRead pulses for one cycle only when !iParamEmpty and the FSM is in a fetch state.
  - The word is captured on the next cycle (an x_DATA state).
  - Throughput is 2 cycles per word when the FIFO never runs empty.
  - While empty, the FSM waits in its fetch state indefinitely.
- FSM states and transitions:
  - IDLE → HDR_DATA: on read of the header word.
  - HDR_DATA:
    - If header[15:12] != MAGIC: set oMagicErr, discard the word, return to IDLE. No result.
    - Otherwise latch relu = header[11] and N = header[10:0], then go to BIAS_FETCH.
  - BIAS_FETCH → BIAS_DATA: on read.
  - BIAS_DATA:
    - acc = sign_extend(bias) << 8, i.e. Q8.8 → Q16.16.
    - If N == 0, go to SAT. Otherwise go to W_FETCH.
  - W_FETCH → W_DATA: on read. W_DATA latches the weight, then goes to X_FETCH.
  - X_FETCH → X_DATA: on read.
  - X_DATA:
    - acc += sign_extend_ACC_W(w × x). The product is a 32-bit signed Q16.16 value.
    - Decrement the pair counter. If it reaches 0, go to SAT; otherwise go to W_FETCH.
  - SAT (1 cycle): compute res, then go to OUT.
    - If acc > 0x7FFFFFFF, res = 0x7FFFFFFF.
    - If acc < −2^31, res = 0x80000000.
    - Otherwise res = acc[31:0].
    - If relu and res is negative, res = 0.
  - OUT:
    - If !iResultFull: oResultWrite = 1 for exactly one cycle, o32ResultData = res, o16ResultCount increments, go to IDLE.
    - If full: hold in OUT with oResultWrite = 0 and res stable.
- o32ResultData holds its last value outside OUT. It is qualified only by oResultWrite.
- The accumulator never wraps; saturation is decided from the full ACC_W value.
- The FSM may issue the next header read only after returning to IDLE. There is no packet overlap.
- oBusy = (state != IDLE).

Test Plan:
- Basic packet: 0xA002, 0x0100, 0x0200, 0x0180, 0xFF00, 0x0100 → one write of 0x00030000; o16ResultCount = 1; oMagicErr = 0.
- ReLU and negative bias:
  - 0xA800, 0xFE00 → write 0x00000000.
  - Same packet with header 0xA000 → write 0xFFFE0000.
- Saturation and N=0:
  - 0xA7FF, 0x0000, then 2047 × (0x7FFF, 0x7FFF) → write 0x7FFFFFFF.
  - 0xA000, 0x8000 → write 0xFF800000.
- Bad magic: 0x1234, then the basic packet → oMagicErr = 1 and stays 1; exactly one write of 0x00030000.
- Backpressure and starvation:
  - Deassert empty only every 5th cycle → same result, and no oParamRead while empty.
  - Hold iResultFull = 1 for 20 cycles at OUT → oResultWrite stays 0 and res is stable; the single write occurs on the first cycle after full drops.
- Reset mid-packet: assert iReset after the bias word → all outputs 0 on the next cycle; a following basic packet yields 0x00030000 with o16ResultCount = 1.
